// File: rtl/draw_cmd_fifo_if.sv
// AXI4-Lite bus bundle between the PS and draw_cmd_fifo.
interface draw_cmd_fifo_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid, awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid, wready;
    logic [1:0]          bresp;
    logic                bvalid, bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid, arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid, rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/draw_cmd_fifo.sv
// AXI4-Lite fed word FIFO; packs WORDS_PER_CMD words per draw-engine command (ap_start/ap_done).
// Define DRAW_CMD_FIFO_IRQ_EN to add the irq output and the IRQ register at 0xC.
module draw_cmd_fifo #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH_LOG2      = 5,
    parameter int WORDS_PER_CMD        = 4
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_areset,
    draw_cmd_fifo_if.slave               s00_axi,
    output logic [32*WORDS_PER_CMD-1:0]  cmd_data,
    output logic                         ap_rst_n,
    output logic                         ap_start,
    input  logic                         ap_done
`ifdef DRAW_CMD_FIFO_IRQ_EN
    ,
    output logic                         irq
`endif
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;
    localparam int IDX_W = $clog2(WORDS_PER_CMD + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

    logic [31:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]           level;
    logic                       enable, overflow;
    logic [31:0]                done_cnt;
    state_t                     state;
    logic [IDX_W-1:0]           idx;

    logic       wr_fire, rd_fire, push_req, push, pop, flush, full, empty, abort, cmd_done;
    logic [1:0] wr_sel, rd_sel;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rd_mux;

    assign wr_sel   = s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-1 -: 2];
    assign rd_sel   = s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-1 -: 2];
    assign wr_fire  = s00_axi.awready & s00_axi.awvalid & s00_axi.wvalid;
    assign rd_fire  = s00_axi.arready & s00_axi.arvalid;
    assign full     = level == LVL_W'(DEPTH);
    assign empty    = level == '0;
    assign push_req = wr_fire && wr_sel == 2'd0;
    assign push     = push_req && !full;
    assign flush    = wr_fire && wr_sel == 2'd1 && s00_axi.wdata[30];
    // A flush landing in LOAD throws away the partially gathered command.
    assign abort    = !enable || (flush && state == S_LOAD);
    assign pop      = state == S_LOAD && !abort;
    assign cmd_done = state == S_WAIT && !abort && ap_done;
    assign ap_rst_n = enable;
    assign s00_axi.rresp = 2'b00;

    logic unused_ok;
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.wstrb,
                         s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-3:0], s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-3:0]};

`ifdef DRAW_CMD_FIFO_IRQ_EN
    logic irq_en, pending;
    assign irq = irq_en & pending;
`endif

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd1: begin
                rd_mux[31]   = enable;
                rd_mux[16]   = full;
                rd_mux[15:8] = 8'(level);
                rd_mux[2]    = state != S_IDLE;
                rd_mux[1]    = overflow;
                rd_mux[0]    = empty;
            end
            2'd2: rd_mux = done_cnt;
`ifdef DRAW_CMD_FIFO_IRQ_EN
            2'd3: begin
                rd_mux[0] = irq_en;
                rd_mux[8] = pending;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
            s00_axi.bresp   <= 2'b00;
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rdata   <= '0;
            enable          <= 1'b0;
            overflow        <= 1'b0;
`ifdef DRAW_CMD_FIFO_IRQ_EN
            irq_en          <= 1'b0;
            pending         <= 1'b0;
`endif
        end else begin
            s00_axi.awready <= !s00_axi.awready && s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid;
            s00_axi.wready  <= !s00_axi.awready && s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid;
            if (wr_fire) begin
                s00_axi.bvalid <= 1'b1;
                s00_axi.bresp  <= (push_req && full) ? 2'b10 : 2'b00;
            end else if (s00_axi.bready) begin
                s00_axi.bvalid <= 1'b0;
            end
            if (push_req && full)
                overflow <= 1'b1;
            else if (wr_fire && wr_sel == 2'd1 && s00_axi.wdata[1])
                overflow <= 1'b0;
            if (wr_fire && wr_sel == 2'd1)
                enable <= s00_axi.wdata[31];
`ifdef DRAW_CMD_FIFO_IRQ_EN
            if (wr_fire && wr_sel == 2'd3)
                irq_en <= s00_axi.wdata[0];
            if (cmd_done && empty)
                pending <= 1'b1;
            else if (wr_fire && wr_sel == 2'd3 && s00_axi.wdata[8])
                pending <= 1'b0;
`endif
            s00_axi.arready <= !s00_axi.arready && s00_axi.arvalid && !s00_axi.rvalid;
            if (rd_fire) begin
                s00_axi.rvalid <= 1'b1;
                s00_axi.rdata  <= rd_mux;
            end else if (s00_axi.rready) begin
                s00_axi.rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (push) mem[wr_ptr] <= s00_axi.wdata;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state    <= S_IDLE;
            idx      <= '0;
            cmd_data <= '0;
            ap_start <= 1'b0;
            done_cnt <= '0;
        end else if (state != S_IDLE && abort) begin
            state    <= S_IDLE;
            ap_start <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (enable && !flush && level >= LVL_W'(WORDS_PER_CMD) && ap_done) begin
                    state <= S_LOAD;
                    idx   <= '0;
                end
                S_LOAD: begin
                    cmd_data[32*idx +: 32] <= mem[rd_ptr];
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(WORDS_PER_CMD - 1)) begin
                        state    <= S_START;
                        ap_start <= 1'b1;
                    end
                end
                S_START: if (!ap_done) begin
                    ap_start <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: if (ap_done) begin
                    done_cnt <= done_cnt + 32'd1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
